ram_sp_be: RTL and testbench

//  Parametrised single-port synchronous RAM; successor to the fixed 8x8 RAM.
//  - Adds byte-enable writes, configurable read latency and a read-valid strobe.
//  - Adds self-clearing after reset and on request, with a busy flag.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_sp_be_array.sv | 52 +++++
 rtl/ram_sp_be.sv | 162 ++++++++++++++++
 tb/tb_ram_sp_be.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable scratch RAM.
package ram_pkg;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // Even parity: the stored bit makes the byte plus parity have an even count of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_sp_be_array.sv
// Storage for ram_sp_be: byte-enable write port and registered read, no reset.
// Parity storage is present only when RAM_PARITY_EN is defined.
module ram_sp_be_array
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef RAM_PARITY_EN
  input  logic [BE_W-1:0]   wpar,
  output logic [BE_W-1:0]   rpar,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  // Non-power-of-2 depths leave a hole in the address space.
  assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= in_range ? mem[addr] : '0;
  end

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) par_mem[addr][i] <= wpar[i];
      end
    end
    if (re) rpar <= in_range ? par_mem[addr] : '0;
  end
`endif

endmodule

// File: rtl/ram_sp_be.sv
// Parametrised single-port RAM with byte enables, self-clear FSM and read pipeline.
// Optional per-byte parity is enabled by defining RAM_PARITY_EN.
module ram_sp_be
  import ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int BE_W    = be_width(DATA_W),
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
`ifdef RAM_PARITY_EN
  input  logic              inj_par,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              arr_we, arr_re;
  logic [BE_W-1:0]   arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic              par_err;
  logic              vld_p0;

  // CLEAR owns the array port; requests are only accepted in IDLE.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_be    = be;
    arr_addr  = addr;
    arr_wdata = wdata;
    case (state)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_be    = '1;
        arr_addr  = ptr;
        arr_wdata = '0;
        ptr_nxt   = ptr + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      IDLE: begin
        arr_we = en & wr;
        arr_re = en & ~wr;
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign busy = (state == CLEAR);

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] arr_wpar, arr_rpar;

  always_comb begin
    arr_wpar = '0;
    if (state == IDLE) begin
      for (int i = 0; i < BE_W; i++) arr_wpar[i] = byte_parity(wdata[i*8 +: 8]) ^ inj_par;
    end
  end

  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (byte_parity(arr_rdata[i*8 +: 8]) != arr_rpar[i]) par_err = 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  ram_sp_be_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BE_W  (BE_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .be   (arr_be),
    .addr (arr_addr),
    .wdata(arr_wdata),
`ifdef RAM_PARITY_EN
    .wpar (arr_wpar),
    .rpar (arr_rpar),
`endif
    .rdata(arr_rdata)
  );

  // Stage p0: array read register and its valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= arr_re;
  end

  if (OUT_REG == 0) begin : g_lat1
    // The array register has no reset, so rdata is masked until the first read lands.
    logic rd_seen;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_seen <= 1'b0;
      else        rd_seen <= rd_seen | arr_re;
    end

    assign rdata  = rd_seen ? arr_rdata : '0;
    assign rvalid = vld_p0;
    assign err    = vld_p0 & par_err;
  end else begin : g_lat2
    // Stage p1: output register
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1, err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
        err_p1   <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        err_p1 <= vld_p0 & par_err;
        if (vld_p0) rdata_p1 <= arr_rdata;
      end
    end

    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;
    assign err    = err_p1;
  end

endmodule

// File: tb/tb_ram_sp_be.sv
// Bench for ram_sp_be: two instances (read latency 1 and 2) share one stimulus stream
// and are checked every cycle against a word-level memory model.
module tb_ram_sp_be;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int BW    = 4;
  localparam int NCYC  = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, wr = 1'b0, clr = 1'b0, inj_par = 1'b0;
  logic [BW-1:0] be = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, busy_a, busy_b, err_a, err_b;

  always #5 clk = ~clk;

  ram_sp_be #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
    .clr(clr),
`ifdef RAM_PARITY_EN
    .inj_par(inj_par),
`endif
    .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a), .err(err_a)
  );

  ram_sp_be #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .be(be), .addr(addr), .wdata(wdata),
    .clr(clr),
`ifdef RAM_PARITY_EN
    .inj_par(inj_par),
`endif
    .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b), .err(err_b)
  );

  wire [69:0] obs = {rvalid_a, rdata_a, err_a, busy_a, rvalid_b, rdata_b, err_b, busy_b};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int clr_left = DEPTH;

  logic [DW-1:0] m  [DEPTH];
  logic [BW-1:0] mp [DEPTH];
  logic          ev_a [NCYC];
  logic          ev_b [NCYC];
  logic          ee_a [NCYC];
  logic          ee_b [NCYC];
  logic [DW-1:0] ed_a [NCYC];
  logic [DW-1:0] ed_b [NCYC];
  logic [DW-1:0] last_a = '0, last_b = '0;
  logic [69:0]   exp_vec;

  function automatic logic word_err(input logic [DW-1:0] d, input logic [BW-1:0] p);
    for (int i = 0; i < BW; i++) if ((^d[i*8 +: 8]) != p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    clr_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      m[i]  = '0;
      mp[i] = '0;
    end
    for (int c = cyc; c < NCYC; c++) begin
      ev_a[c] = 1'b0; ev_b[c] = 1'b0; ee_a[c] = 1'b0; ee_b[c] = 1'b0;
      ed_a[c] = '0;   ed_b[c] = '0;
    end
    last_a = '0;
    last_b = '0;
  endtask

  // Advance one clock, apply the request rules to the model, then settle.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else if (clr_left > 0) clr_left--;
    else begin
      if (en && wr) begin
        for (int i = 0; i < BW; i++) begin
          if (be[i]) begin
            m[addr][i*8 +: 8] = wdata[i*8 +: 8];
            mp[addr][i]       = (^wdata[i*8 +: 8]) ^ inj_par;
          end
        end
      end else if (en) begin
        ev_a[cyc] = 1'b1;     ed_a[cyc] = m[addr];     ee_a[cyc] = word_err(m[addr], mp[addr]);
        ev_b[cyc + 1] = 1'b1; ed_b[cyc + 1] = m[addr]; ee_b[cyc + 1] = word_err(m[addr], mp[addr]);
      end
      if (clr) begin
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          m[i]  = '0;
          mp[i] = '0;
        end
      end
    end
    if (ev_a[cyc]) last_a = ed_a[cyc];
    if (ev_b[cyc]) last_b = ed_b[cyc];
    exp_vec = {ev_a[cyc], last_a, ev_a[cyc] & ee_a[cyc], clr_left > 0,
               ev_b[cyc], last_b, ev_b[cyc] & ee_b[cyc], clr_left > 0};
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [BW-1:0] b,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
    en = e; wr = w; be = b; addr = a; wdata = d; clr = c;
  endtask

  task automatic test_reset();
    int busy_cnt;
    rst_n = 1'b0;
    drive(0, 0, '0, '0, '0, 0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      cycle();
      if (busy_a) busy_cnt++;
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_clear cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    n_tests++;
    if (busy_cnt !== DEPTH - 1) begin
      n_fail++;
      $display("FAIL reset_busy_len got=%0d exp=%0d", busy_cnt + 1, DEPTH);
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k < DEPTH) drive(1, 0, '0, AW'(k), '0, 0);
      else           drive(0, 0, '0, '0, '0, 0);
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_readback cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] wd [4] = '{32'hAABBCCDD, 32'h11223344, 32'hFFFFFFFF, 32'h0};
    logic [BW-1:0] wb [4] = '{4'b1111, 4'b0101, 4'b0000, 4'b0000};
    for (int k = 0; k < 7; k++) begin
      if (k < 3)       drive(1, 1, wb[k], 3'd3, wd[k], 0);
      else if (k == 3) drive(1, 0, '0, 3'd3, '0, 0);
      else             drive(0, 0, '0, '0, '0, 0);
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL byte_enable cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (k == 3) begin
        n_tests++;
        if (rdata_a !== 32'hAA22CC44 || rvalid_a !== 1'b1) begin
          n_fail++;
          $display("FAIL be_merge got=%h/%b exp=aa22cc44/1", rdata_a, rvalid_a);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 9; k++) begin
      if (k < 3)      drive(1, 1, 4'hF, AW'(k), $urandom, 0);
      else if (k < 6) drive(1, 0, '0, AW'(k - 3), '0, 0);
      else            drive(0, 0, '0, '0, '0, 0);
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_clear();
    int guard;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 1, 4'hF, AW'(a), $urandom | 32'h1, 0);
      cycle();
    end
    drive(0, 0, '0, '0, '0, 1);
    cycle();
    n_tests++;
    if (obs !== exp_vec) begin
      n_fail++;
      $display("FAIL clear_start cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
    end
    guard = 0;
    while (clr_left > 0 && guard < 20) begin
      if (guard == 0)      drive(1, 0, '0, 3'd2, '0, 0);
      else if (guard == 1) drive(1, 1, 4'hF, 3'd1, 32'hFFFFFFFF, 0);
      else                 drive(0, 0, '0, '0, '0, 0);
      cycle();
      guard++;
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL clear_busy cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    n_tests++;
    if (busy_a !== 1'b0 || guard >= 20) begin
      n_fail++;
      $display("FAIL clear_timeout busy=%b exp=0 cycles=%0d", busy_a, guard);
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k < DEPTH) drive(1, 0, '0, AW'(k), '0, 0);
      else           drive(0, 0, '0, '0, '0, 0);
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL clear_readback cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 4'hF, 3'd4, 32'hC0FFEE11, 0);
    cycle();
    drive(1, 0, '0, 3'd4, '0, 0);
    cycle();
    n_tests++;
    if (obs !== exp_vec) begin
      n_fail++;
      $display("FAIL rstmid_req cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
    end
    drive(0, 0, '0, '0, '0, 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_tests++;
    if (obs !== exp_vec || rvalid_b !== 1'b0 || rdata_b !== '0) begin
      n_fail++;
      $display("FAIL rstmid_drop got=%h exp=%h", obs, exp_vec);
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_clear cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 6; k++) begin
      inj_par = (k == 0);
      if (k == 0 || k == 3) drive(1, 1, 4'b0001, 3'd5, $urandom, 0);
      else if (k == 1 || k == 4) drive(1, 0, '0, 3'd5, '0, 0);
      else drive(0, 0, '0, '0, '0, 0);
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL parity cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (k == 1 || k == 4) begin
        n_tests++;
        if (err_a !== (k == 1) || rvalid_a !== 1'b1) begin
          n_fail++;
          $display("FAIL parity_err step=%0d got=%b exp=%b", k, err_a, (k == 1));
        end
      end
    end
    inj_par = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, BW'($urandom),
            AW'($urandom), $urandom, $urandom_range(31, 0) == 0);
`ifdef RAM_PARITY_EN
      inj_par = $urandom_range(7, 0) == 0;
`endif
      cycle();
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    inj_par = 1'b0;
    drive(0, 0, '0, '0, '0, 0);
    for (int k = 0; k < DEPTH + 2; k++) cycle();
  endtask

  initial begin
    #1;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_clear();
    test_reset_mid();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
